// File: rtl/mc_option_core.sv
// American-put Monte Carlo core: Longstaff-Schwartz with a mean (degree-0) continuation
// estimate, streaming NPATH samples per exercise date in two passes over a cash-flow memory.
module mc_option_core #(
  parameter int NPATH = 256,
  parameter int NDAY  = 8,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] path,
  input  logic [W-1:0] K,
  output logic         resend,
  output logic         valid,
  output logic [W-1:0] price
);

  localparam int LOGN   = $clog2(NPATH);
  localparam int DAY_W  = $clog2(NDAY);
  localparam int SY_W   = W + LOGN;      // in-the-money cash sum
  localparam int SUM_W  = W + LOGN + 1;  // final cash sum
  localparam int CNT_W  = 5;
  localparam int FRAC   = 8;

  localparam logic [LOGN-1:0]  IDX_LAST  = LOGN'(NPATH - 1);
  localparam logic [DAY_W-1:0] DAY_LAST  = DAY_W'(NDAY - 1);
  localparam logic [CNT_W-1:0] CALC_LAST = CNT_W'(15);
  localparam logic [CNT_W-1:0] DIV_STEPS = CNT_W'(W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    PASS1 = 3'd2,
    CALC  = 3'd3,
    PASS2 = 3'd4,
    NEXT  = 3'd5,
    DONE  = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LOGN-1:0]    idx_q, idx_d;
  logic [DAY_W-1:0]   day_q, day_d;
  logic [LOGN:0]      n_q, n_d;
  logic [SY_W-1:0]    sumy_q, sumy_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [LOGN:0]      rem_q, rem_d;
  logic [W-1:0]       quo_q, quo_d;
  logic               resend_q, resend_d;
  logic               valid_q, valid_d;
  logic [W-1:0]       price_q, price_d;

  logic [W-1:0]       cash_q [NPATH];
  logic [W-1:0]       cash_rd;
  logic               cash_we;
  logic               clear;

  logic               itm;
  logic [W-1:0]       payoff;
  logic [W-1:0]       cont;
  logic               exercise;
  logic [LOGN+1:0]    trial;
  logic [LOGN+1:0]    n_ext;
  logic               div_ge;

  assign itm      = (path < K);
  assign payoff   = itm ? (K - path) : '0;
  assign cash_rd  = cash_q[idx_q];
  assign cont     = (n_q == '0) ? '0 : quo_q;
  assign exercise = itm && (payoff > cont);

  // Restoring division producing only the low W quotient bits: every cash entry is
  // below 2^W, so the mean is too and the top of sumY is already smaller than n.
  assign trial  = {rem_q, quo_q[W-1]};
  assign n_ext  = {1'b0, n_q};
  assign div_ge = (trial >= n_ext);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    day_d    = day_q;
    n_d      = n_q;
    sumy_d   = sumy_q;
    sum_d    = sum_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    resend_d = 1'b0;
    valid_d  = 1'b0;
    price_d  = price_q;
    cash_we  = 1'b0;
    clear    = 1'b0;

    if (start) begin
      state_d = WAIT;
      cnt_d   = '0;
      idx_d   = '0;
      day_d   = '0;
      n_d     = '0;
      sumy_d  = '0;
      sum_d   = '0;
      rem_d   = '0;
      quo_d   = '0;
      clear   = 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        WAIT: begin
          if (cnt_q == '0) state_d = PASS1;
          else             cnt_d   = cnt_q - 1'b1;
        end
        PASS1: begin
          if (itm) begin
            n_d    = n_q + 1'b1;
            sumy_d = sumy_q + SY_W'(cash_rd);
          end
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = CALC;
            cnt_d   = '0;
          end
        end
        CALC: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '0) begin
            rem_d = (LOGN+1)'(sumy_q >> W);
            quo_d = sumy_q[W-1:0];
          end else if (cnt_q <= DIV_STEPS) begin
            rem_d = div_ge ? (LOGN+1)'(trial - n_ext) : trial[LOGN:0];
            quo_d = {quo_q[W-2:0], div_ge};
          end
          if (cnt_q == CALC_LAST) begin
            resend_d = 1'b1;
            state_d  = PASS2;
          end
        end
        PASS2: begin
          cash_we = exercise;
          sum_d   = sum_q + SUM_W'(exercise ? payoff : cash_rd);
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            cnt_d   = '0;
            state_d = (day_q == DAY_LAST) ? DONE : NEXT;
          end
        end
        NEXT: begin
          if (cnt_q == CNT_W'(1)) begin
            resend_d = 1'b1;
            day_d    = day_q + 1'b1;
            n_d      = '0;
            sumy_d   = '0;
            sum_d    = '0;
            cnt_d    = CNT_W'(1);
            state_d  = WAIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE: begin
          price_d = W'(sum_q >> FRAC);
          valid_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      day_q    <= '0;
      n_q      <= '0;
      sumy_q   <= '0;
      sum_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      resend_q <= 1'b0;
      valid_q  <= 1'b0;
      price_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      day_q    <= day_d;
      n_q      <= n_d;
      sumy_q   <= sumy_d;
      sum_q    <= sum_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      resend_q <= resend_d;
      valid_q  <= valid_d;
      price_q  <= price_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPATH; i++) cash_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NPATH; i++) cash_q[i] <= '0;
    end else if (cash_we) begin
      cash_q[idx_q] <= payoff;
    end
  end

  assign resend = resend_q;
  assign valid  = valid_q;
  assign price  = price_q;

endmodule

// File: tb/tb_mc_option_core.sv
// Directed bench for mc_option_core: plays the path source, checks capture/resend/valid
// timing, pulse counts and the final price for hand-computed patterns.
module tb_mc_option_core;

  localparam logic [11:0] JUNK = 12'h000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] path;
  logic [11:0] K;
  logic        resend;
  logic        valid;
  logic [11:0] price;

  int checks = 0;
  int errors = 0;
  int resend_seen = 0;
  int valid_seen = 0;
  int overlap_seen = 0;

  always #5 clk = ~clk;

  mc_option_core dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .path   (path),
    .K      (K),
    .resend (resend),
    .valid  (valid),
    .price  (price)
  );

  always @(negedge clk) begin
    if (resend) resend_seen++;
    if (valid) valid_seen++;
    if (resend && valid) overlap_seen++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] sample(input int pat, input int d, input int j);
    case (pat)
      1: return 12'h400;
      2: return 12'h100;
      3: return (d == 0) ? 12'h200 : ((d == 1) ? 12'h000 : 12'h400);
      4: return (d == 0 && j < 128) ? 12'h000 : 12'h400;
      default: return 12'h400;
    endcase
  endfunction

  // Runs one pricing job. abort_day >= 0 pulls reset in that day's second pass.
  task automatic run_price(input int pat, input int abort_day,
                           input logic [11:0] prev_price, input logic [11:0] exp_price);
    int r0, v0, o0, c;
    r0 = resend_seen;
    v0 = valid_seen;
    o0 = overlap_seen;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("price_hold_on_start", price, prev_price);
    tick();
    for (int d = 0; d < 8; d++) begin
      for (int p = 1; p <= 2; p++) begin
        if (p == 1 && d > 0) begin
          tick();
          tick();
        end
        for (int j = 0; j < 256; j++) begin
          if (d == abort_day && p == 2 && j == 100) begin
            rst_n = 1'b0;
            #1;
            chk("abort_resend", resend, 1'b0);
            chk("abort_valid", valid, 1'b0);
            chk("abort_price", price, 12'h000);
            return;
          end
          path = sample(pat, d, j);
          tick();
          if (d == 0 && p == 2 && j == 0) chk("resend_width", resend, 1'b0);
        end
        path = JUNK;
        if (p == 1 || d < 7) begin
          c = 0;
          do begin
            tick();
            c++;
          end while (!resend && c < 40);
          chk($sformatf("resend_latency_d%0d_p%0d", d, p), c, (p == 1) ? 16 : 2);
          if (!resend) return;
        end else begin
          c = 0;
          do begin
            tick();
            c++;
          end while (!valid && c < 8);
          chk("valid_within_4", (valid && c <= 4), 1'b1);
          chk("price", price, exp_price);
        end
      end
    end
    repeat (6) tick();
    chk("resend_count", resend_seen - r0, 15);
    chk("valid_count", valid_seen - v0, 1);
    chk("no_overlap", overlap_seen - o0, 0);
    chk("price_held_after", price, exp_price);
  endtask

  initial begin
    int r_ab, v_ab;
    rst_n = 1'b0;
    start = 1'b0;
    path  = JUNK;
    K     = 12'h300;
    repeat (3) tick();
    chk("reset_resend", resend, 1'b0);
    chk("reset_valid", valid, 1'b0);
    chk("reset_price", price, 12'h000);
    rst_n = 1'b1;
    repeat (2) tick();

    run_price(1, -1, 12'h000, 12'h000);
    run_price(2, -1, 12'h000, 12'h200);
    run_price(3, -1, 12'h200, 12'h300);
    run_price(4, -1, 12'h300, 12'h180);

    run_price(2, 3, 12'h180, 12'h200);
    r_ab = resend_seen;
    v_ab = valid_seen;
    path = JUNK;
    repeat (5) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    chk("abort_no_resend", resend_seen - r_ab, 0);
    chk("abort_no_valid", valid_seen - v_ab, 0);

    run_price(2, -1, 12'h000, 12'h200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
